// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat FSM states, default
// timing constants and the counter width helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } repeat_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

    // Bits needed to count 0 .. terminal-1, never fewer than one.
    function automatic int counter_width(input int terminal);
        return (terminal < 2) ? 1 : $clog2(terminal);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-level debounce counter and
// a one-cycle strobe marking the cycle the debounced level rose.
module debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              COUNT_W  = counter_width(DEBOUNCE_CYCLES);
    localparam logic [COUNT_W-1:0] TERMINAL = COUNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync_meta_reg;
    logic               sync_reg;
    logic               level_reg;
    logic               rise_reg;
    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            level_reg     <= 1'b0;
            rise_reg      <= 1'b0;
            count_reg     <= '0;
        end else begin
            sync_meta_reg <= raw;
            sync_reg      <= sync_meta_reg;
            rise_reg      <= 1'b0;
            // Any agreement restarts the stability window, so glitches vanish.
            if (sync_reg == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == TERMINAL) begin
                level_reg <= sync_reg;
                rise_reg  <= sync_reg;
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/button_conditioner.sv
// Debounces left/right/throw buttons into held levels and command strobes.
// Define BTN_AUTOREPEAT_EN to add auto-repeat on the left and right buttons.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic CLK,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic throw_raw,
    output logic left_pulse,
    output logic right_pulse,
    output logic throw_pulse,
    output logic left_held,
    output logic right_held,
    output logic throw_held
);

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_THROW = 2;
    localparam int NUM_CH   = 3;

    // Out-of-range timing parameters silence the strobes instead of misfiring.
    localparam logic CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 2) &&
                              (REPEAT_PERIOD >= 2);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REPEAT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REPEAT_W    = counter_width(REPEAT_SPAN);
    localparam logic [REPEAT_W-1:0] DELAY_LAST  = REPEAT_W'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_W-1:0] PERIOD_LAST = REPEAT_W'(REPEAT_PERIOD - 1);
`endif

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] strobe;
    logic              throw_pulse_reg;

    assign raw = {throw_raw, right_raw, left_raw};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (CLK),
                .reset (reset),
                .raw   (raw[gi]),
                .level (level[gi]),
                .rise  (rise[gi])
            );
        end

        for (gi = CH_LEFT; gi <= CH_RIGHT; gi++) begin : g_dir
`ifdef BTN_AUTOREPEAT_EN
            repeat_state_t       state_reg;
            logic [REPEAT_W-1:0] count_reg;
            logic                pulse_reg;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= 1'b0;
                    // Release from any state drops back to IDLE; timing keeps
                    // running while arbitration masks the strobe.
                    if (!level[gi]) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                if (rise[gi]) begin
                                    pulse_reg <= 1'b1;
                                    state_reg <= DELAY;
                                    count_reg <= '0;
                                end
                            end
                            DELAY: begin
                                if (count_reg == DELAY_LAST) begin
                                    pulse_reg <= 1'b1;
                                    state_reg <= REPEAT;
                                    count_reg <= '0;
                                end else begin
                                    count_reg <= count_reg + 1'b1;
                                end
                            end
                            REPEAT: begin
                                if (count_reg == PERIOD_LAST) begin
                                    pulse_reg <= 1'b1;
                                    count_reg <= '0;
                                end else begin
                                    count_reg <= count_reg + 1'b1;
                                end
                            end
                            default: begin
                                state_reg <= IDLE;
                                count_reg <= '0;
                            end
                        endcase
                    end
                end
            end
`else
            logic pulse_reg;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= rise[gi];
                end
            end
`endif
            assign strobe[gi] = pulse_reg;
        end
    endgenerate

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            throw_pulse_reg <= 1'b0;
        end else begin
            throw_pulse_reg <= rise[CH_THROW];
        end
    end

    assign strobe[CH_THROW] = throw_pulse_reg;

    assign left_held  = level[CH_LEFT];
    assign right_held = level[CH_RIGHT];
    assign throw_held = level[CH_THROW];

    // Both directions down at once is ambiguous, so neither may strobe.
    assign left_pulse  = CFG_OK & strobe[CH_LEFT]  & level[CH_LEFT]  & ~level[CH_RIGHT];
    assign right_pulse = CFG_OK & strobe[CH_RIGHT] & level[CH_RIGHT] & ~level[CH_LEFT];
    assign throw_pulse = CFG_OK & strobe[CH_THROW];

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required to accept a new input level (10 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from first pulse to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have ports: CLK  input  1  system clock; one clock, all logic on posedge CLK.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 left_raw, right_raw, throw_raw  input  1 each  unsynchronized push-button levels, 1 = pressed.
REQ-007 left_pulse, right_pulse, throw_pulse  output  1 each  single-CLK-cycle command strobes to game logic.
REQ-008 left_held, right_held, throw_held  output  1 each  debounced button levels.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Per channel, debounce counter SHALL clear whenever synchronized level equals debounced level, else increment; when it reaches DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-011 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on *_held or *_pulse.
REQ-012 *_held SHALL equal the debounced level; *_pulse SHALL assert for exactly one cycle, the cycle after the debounced level rises (latency raw edge to pulse = 2 + DEBOUNCE_CYCLES + 1 cycles).
REQ-013 Release (debounced fall) SHALL produce no pulse.
REQ-014 If left and right debounced levels are both 1 in a cycle, left_pulse and right_pulse SHALL both be 0 that cycle, including the case where both rise in the same cycle.
REQ-015 throw_pulse SHALL be independent of left/right and SHALL never auto-repeat.
REQ-016 Left/right repeat FSM per channel: IDLE -> DELAY on debounced rise (initial pulse); DELAY -> REPEAT after REPEAT_DELAY cycles (pulse); in REPEAT one pulse every REPEAT_PERIOD cycles; any state -> IDLE on debounced fall, repeat counter cleared.
REQ-017 Repeat pulses SHALL also be subject to REQ-014; FSM timing continues while suppressed.
REQ-018 Counter widths SHALL be $clog2 of their parameter (minimum 1 bit); parameters SHALL be >= 2; counters SHALL never wrap past their terminal value.

Reset
REQ-019 On reset assertion, asynchronously: all outputs 0, synchronizer flops 0, debounced levels 0, all counters 0, FSMs IDLE.
REQ-020 A button held through reset deassertion SHALL be treated as a new press: full debounce, then one pulse.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted in the reset cycle.

Configuration
REQ-022 Macro BTN_AUTOREPEAT_EN: when defined, REQ-016/017 SHALL be compiled in; when undefined, repeat FSM and counters SHALL be absent and each press SHALL yield exactly one pulse regardless of hold time.

Structure
REQ-023 A shared package SHALL hold the repeat FSM state enum (IDLE, DELAY, REPEAT) and default parameter constants.
REQ-024 One sub-module debounce_ch (synchronizer + debounce counter + rise detect, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times; left/right arbitration and repeat FSMs live in the top.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_AUTOREPEAT_EN defined)
REQ-025 left_raw 0->1 held 8 cycles -> left_held rises cycle 6, left_pulse high only cycle 7 after edge.
REQ-026 throw_raw pulsed high 3 cycles then low -> throw_held and throw_pulse stay 0.
REQ-027 right_raw held 30 cycles -> pulses at cycle 7, 17, 20, 23, 26, 29 after edge; release -> no further pulses.
REQ-028 left_raw and right_raw rise same cycle, held 30 cycles -> no left_pulse or right_pulse; left_held=right_held=1.
REQ-029 left held, reset asserted 2 cycles at cycle 12 -> outputs 0 immediately; after deassertion single pulse 7 cycles later, repeat timing restarts.
REQ-030 BTN_AUTOREPEAT_EN undefined, left held 50 cycles -> exactly one left_pulse.
